keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 235 +++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-hot column drive, synchronised row sampling,
// frame-based press/release debounce and key-map decode of accepted keys.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] key_row_i,
  output logic [3:0] key_col_o,
  output logic [3:0] keyboard_row_o,
  output logic [3:0] keyboard_col_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_held_o
);

  localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam bit                DB_ONE    = (DEBOUNCE_FRAMES == 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PRESS_DB = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;
  localparam logic [1:0] ST_REL_DB   = 2'd3;

  logic [3:0]        row_s1_q, row_s2_q;
  logic [SLOT_W-1:0] slot_q;
  logic [3:0]        col_q;
  logic              seen_q, multi_q;
  logic [3:0]        hit_row_q, hit_col_q;
  logic [1:0]        state_q, state_d;
  logic [3:0]        cand_row_q, cand_row_d, cand_col_q, cand_col_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [3:0]        code_q, code_d, krow_q, krow_d, kcol_q, kcol_d;
  logic              valid_q, valid_d, held_q, held_d;

  logic       tick, frame_end, slot_hit, slot_onehot;
  logic       f_none, f_multi, f_single, same_key, enter;
  logic [3:0] f_row, f_col;

  // Key map: (row one-hot, col one-hot) -> key value
  function automatic logic [3:0] decode(input logic [3:0] row, input logic [3:0] col);
    logic [3:0] val;
    case ({row, col})
      8'b0001_0001: val = 4'd1;
      8'b0001_0010: val = 4'd2;
      8'b0001_0100: val = 4'd3;
      8'b0001_1000: val = 4'd10;
      8'b0010_0001: val = 4'd4;
      8'b0010_0010: val = 4'd5;
      8'b0010_0100: val = 4'd6;
      8'b0010_1000: val = 4'd11;
      8'b0100_0001: val = 4'd7;
      8'b0100_0010: val = 4'd8;
      8'b0100_0100: val = 4'd9;
      8'b0100_1000: val = 4'd12;
      8'b1000_0001: val = 4'd14;
      8'b1000_0010: val = 4'd0;
      8'b1000_0100: val = 4'd15;
      8'b1000_1000: val = 4'd13;
      default:      val = 4'd0;
    endcase
    return val;
  endfunction

  assign tick        = (slot_q == SLOT_LAST);
  assign frame_end   = tick & col_q[3];
  assign slot_hit    = |row_s2_q;
  assign slot_onehot = ((row_s2_q & (row_s2_q - 4'd1)) == 4'd0);

  // Frame classification including the slot sampled on this tick
  assign f_none   = ~seen_q & ~slot_hit;
  assign f_multi  = multi_q | (slot_hit & (seen_q | ~slot_onehot));
  assign f_single = ~f_none & ~f_multi;
  assign f_row    = slot_hit ? row_s2_q : hit_row_q;
  assign f_col    = slot_hit ? col_q : hit_col_q;
  assign same_key = (f_row == cand_row_q) && (f_col == cand_col_q);
  assign cnt_inc  = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);

  // Two-stage synchroniser for the asynchronous row lines
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      row_s1_q <= 4'd0;
      row_s2_q <= 4'd0;
    end else begin
      row_s1_q <= key_row_i;
      row_s2_q <= row_s1_q;
    end
  end

  // Slot timer and column rotation
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      slot_q <= '0;
      col_q  <= 4'b0001;
    end else if (tick) begin
      slot_q <= '0;
      col_q  <= {col_q[2:0], col_q[3]};
    end else begin
      slot_q <= slot_q + SLOT_W'(1);
    end
  end

  // Per-frame accumulation of row hits, cleared when the frame is evaluated
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      seen_q    <= 1'b0;
      multi_q   <= 1'b0;
      hit_row_q <= 4'd0;
      hit_col_q <= 4'd0;
    end else if (frame_end) begin
      seen_q    <= 1'b0;
      multi_q   <= 1'b0;
      hit_row_q <= 4'd0;
      hit_col_q <= 4'd0;
    end else if (tick && slot_hit) begin
      seen_q    <= 1'b1;
      multi_q   <= multi_q | seen_q | ~slot_onehot;
      hit_row_q <= row_s2_q;
      hit_col_q <= col_q;
    end
  end

  // Debounce FSM and output register state
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      cand_row_q <= 4'd0;
      cand_col_q <= 4'd0;
      cnt_q      <= '0;
      code_q     <= 4'd0;
      krow_q     <= 4'd0;
      kcol_q     <= 4'd0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_row_q <= cand_row_d;
      cand_col_q <= cand_col_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      krow_q     <= krow_d;
      kcol_q     <= kcol_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
    end
  end

  // Next-state and registered-output logic; transitions only at frame end
  always_comb begin
    state_d    = state_q;
    cand_row_d = cand_row_q;
    cand_col_d = cand_col_q;
    cnt_d      = cnt_q;
    enter      = 1'b0;
    if (frame_end) begin
      case (state_q)
        ST_IDLE: begin
          if (f_single) begin
            cand_row_d = f_row;
            cand_col_d = f_col;
            cnt_d      = CNT_ONE;
            if (DB_ONE) begin
              state_d = ST_PRESSED;
              enter   = 1'b1;
            end else begin
              state_d = ST_PRESS_DB;
            end
          end
        end
        ST_PRESS_DB: begin
          if (f_single && same_key) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_FULL) begin
              state_d = ST_PRESSED;
              enter   = 1'b1;
            end
          end else if (f_single) begin
            cand_row_d = f_row;
            cand_col_d = f_col;
            cnt_d      = CNT_ONE;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_PRESSED: begin
          if (f_none) begin
            cnt_d   = CNT_ONE;
            state_d = DB_ONE ? ST_IDLE : ST_REL_DB;
          end
        end
        ST_REL_DB: begin
          if (f_none) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_FULL) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end else begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    code_d  = code_q;
    krow_d  = krow_q;
    kcol_d  = kcol_q;
    if (enter) begin
      code_d = decode(f_row, f_col);
      krow_d = f_row;
      kcol_d = f_col;
    end
    valid_d = enter;
    held_d  = (state_d == ST_PRESSED) || (state_d == ST_REL_DB);
  end

  assign key_col_o      = col_q;
  assign keyboard_row_o = krow_q;
  assign keyboard_col_o = kcol_q;
  assign key_code_o     = code_q;
  assign key_valid_o    = valid_q;
  assign key_held_o     = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a simulated 4x4 matrix driven from a pressed-key
// mask, directed frame tables, hand corner sequences and random frames
// checked against a frame-window debounce model.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DF       = 3;
  localparam int unsigned FRAME    = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_row, key_col, kb_row, kb_col, code;
  logic        valid, held;
  logic [15:0] mask;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] mask;
    logic        valid;
    logic        held;
    logic [3:0]  code;
  } vec_t;
  vec_t vq[$];

  // Key value for key index row*4+col
  int code_tab[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  // Model state
  int hist[$];
  bit m_held;
  int m_code;
  int m_key;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DF)) dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .key_row_i      (key_row),
    .key_col_o      (key_col),
    .keyboard_row_o (kb_row),
    .keyboard_col_o (kb_col),
    .key_code_o     (code),
    .key_valid_o    (valid),
    .key_held_o     (held)
  );

  always #5 clk = ~clk;

  // Switch matrix: a pressed key connects its column drive to its row
  always_comb begin
    key_row = 4'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[r*4+c] && key_col[c]) key_row[r] = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [15:0] m, input logic v, input logic h, input logic [3:0] c);
    vec_t e;
    e.mask = m; e.valid = v; e.held = h; e.code = c;
    vq.push_back(e);
  endtask

  function automatic int frame_result(input logic [15:0] m);
    int n = 0;
    int k = -1;
    for (int i = 0; i < 16; i++) if (m[i]) begin n++; k = i; end
    if (n == 0) return -1;
    if (n == 1) return k;
    return -2;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_held = 1'b0;
    m_code = 0;
    m_key  = -1;
  endtask

  // Press accepted when the last DF frames all saw the same single key;
  // release when the last DF frames were all empty.
  task automatic model_frame(input logic [15:0] m, output bit pulse);
    bit all_same;
    hist.push_back(frame_result(m));
    if (hist.size() > DF) void'(hist.pop_front());
    pulse = 1'b0;
    all_same = (hist.size() == DF);
    for (int i = 1; i < hist.size(); i++) if (hist[i] != hist[0]) all_same = 1'b0;
    if (!m_held && all_same && hist[0] >= 0) begin
      pulse  = 1'b1;
      m_held = 1'b1;
      m_key  = hist[0];
      m_code = code_tab[hist[0]];
    end else if (m_held && all_same && hist[0] == -1) begin
      m_held = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [15:0] m);
    mask = m;
    repeat (FRAME) @(posedge clk);
    #1;
  endtask

  // Asynchronous reset between edges, checked before the next clock edge
  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_col", key_col, 4'b0001);
    check("async_rst_kbrow", kb_row, 0);
    check("async_rst_kbcol", kb_col, 0);
    check("async_rst_code", code, 0);
    check("async_rst_valid", valid, 0);
    check("async_rst_held", held, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int extra;
    bit pulse;
    logic [15:0] m;
    logic [3:0] er, ec;

    rst  = 1'b1;
    mask = 16'h0;
    model_reset();
    #2;
    check("reset_col", key_col, 4'b0001);
    check("reset_kbrow", kb_row, 0);
    check("reset_kbcol", kb_col, 0);
    check("reset_code", code, 0);
    check("reset_valid", valid, 0);
    check("reset_held", held, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Key row 0010 / col 0100: latency, decode and single pulse
    mask = 16'h0040;
    cyc  = 0;
    while (!valid && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("press_latency_in_range", (cyc >= 32 && cyc <= 50), 1);
    check("press_code", code, 6);
    check("press_kbrow", kb_row, 4'b0010);
    check("press_kbcol", kb_col, 4'b0100);
    check("press_held", held, 1);
    @(posedge clk);
    #1;
    check("pulse_one_cycle", valid, 0);
    extra = 0;
    repeat (10 * FRAME) begin
      @(posedge clk);
      #1 if (valid) extra++;
    end
    check("no_repeat_pulse", extra, 0);
    check("still_held", held, 1);
    do_reset();

    // Frame-by-frame directed table
    add(16'h0040, 0, 0, 0);  add(16'h0040, 0, 0, 0);  add(16'h0040, 1, 1, 6);
    add(16'h0040, 0, 1, 6);
    add(16'h0000, 0, 1, 6);  add(16'h0000, 0, 1, 6);  add(16'h0000, 0, 0, 6);
    add(16'h1000, 0, 0, 6);  add(16'h0000, 0, 0, 6);  add(16'h0000, 0, 0, 6);
    add(16'h1000, 0, 0, 6);  add(16'h1000, 0, 0, 6);  add(16'h1000, 1, 1, 14);
    add(16'h1000, 0, 1, 14);
    add(16'h0000, 0, 1, 14); add(16'h1000, 0, 1, 14);
    add(16'h0000, 0, 1, 14); add(16'h0000, 0, 1, 14); add(16'h0000, 0, 0, 14);
    add(16'h1000, 0, 0, 14); add(16'h1000, 0, 0, 14); add(16'h1000, 1, 1, 14);
    add(16'h0000, 0, 1, 14); add(16'h0000, 0, 1, 14); add(16'h0000, 0, 0, 14);
    add(16'h0022, 0, 0, 14); add(16'h0022, 0, 0, 14); add(16'h0022, 0, 0, 14);
    add(16'h0020, 0, 0, 14); add(16'h0020, 0, 0, 14); add(16'h0020, 1, 1, 5);
    add(16'h0000, 0, 1, 5);  add(16'h0000, 0, 1, 5);  add(16'h0000, 0, 0, 5);
    add(16'h0001, 0, 0, 5);  add(16'h8000, 0, 0, 5);  add(16'h8000, 0, 0, 5);
    add(16'h8000, 1, 1, 13);
    add(16'h0000, 0, 1, 13); add(16'h0000, 0, 1, 13); add(16'h0000, 0, 0, 13);
    foreach (vq[i]) begin
      run_frame(vq[i].mask);
      check($sformatf("tbl%0d_valid", i), valid, vq[i].valid);
      check($sformatf("tbl%0d_held", i), held, vq[i].held);
      check($sformatf("tbl%0d_code", i), code, vq[i].code);
    end

    // Reset while pressed with the key still down, then re-acceptance
    run_frame(16'h0040);
    run_frame(16'h0040);
    run_frame(16'h0040);
    check("pre_rst_pulse", valid, 1);
    run_frame(16'h0040);
    check("pre_rst_held", held, 1);
    do_reset();
    run_frame(16'h0040);
    check("post_rst_f1_valid", valid, 0);
    run_frame(16'h0040);
    check("post_rst_f2_valid", valid, 0);
    check("post_rst_f2_code", code, 0);
    run_frame(16'h0040);
    check("post_rst_f3_valid", valid, 1);
    check("post_rst_f3_code", code, 6);
    check("post_rst_f3_held", held, 1);
    do_reset();

    // Random frames against the window model
    m = 16'h0;
    for (int f = 0; f < 300; f++) begin
      int r;
      int a;
      int b;
      r = $urandom_range(0, 9);
      if (r >= 5 && r <= 6) m = 16'h0;
      else if (r >= 7 && r <= 8) m = 16'(1) << $urandom_range(0, 15);
      else if (r == 9) begin
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        m = (16'(1) << a) | (16'(1) << b);
      end
      run_frame(m);
      model_frame(m, pulse);
      er = (m_key < 0) ? 4'd0 : (4'b0001 << (m_key / 4));
      ec = (m_key < 0) ? 4'd0 : (4'b0001 << (m_key % 4));
      check($sformatf("rnd%0d_valid", f), valid, pulse);
      check($sformatf("rnd%0d_held", f), held, m_held);
      check($sformatf("rnd%0d_code", f), code, m_code);
      check($sformatf("rnd%0d_kbrow", f), kb_row, er);
      check($sformatf("rnd%0d_kbcol", f), kb_col, ec);
      check($sformatf("rnd%0d_col", f), key_col, 4'b0001);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
